// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/stall controller: a RUN/DWAIT/HALTED FSM with Mealy write-enable and flush
// outputs, plus saturating stall and flush event counters.
module pipeline_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mem_DRE,
    input  logic             mem_DWE,
    input  logic             mem_brtaken,
    input  logic             ex_DRE,
    input  logic [4:0]       ex_rt,
    input  logic [4:0]       id_rsel1,
    input  logic [4:0]       id_rsel2,
    input  logic             wb_HALT,
    output logic             pc_W,
    output logic             ifid_W,
    output logic             idex_W,
    output logic             exmem_W,
    output logic             memwb_W,
    output logic             ifid_RST,
    output logic             idex_RST,
    output logic             exmem_RST,
    output logic             memwb_RST,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {StRun, StDwait, StHalted} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] stall_q, flush_q;
    logic             dmiss, luhaz, stall_inc, flush_inc;

    assign dmiss = (mem_DRE | mem_DWE) & ~dhit;
    assign luhaz = ex_DRE && (ex_rt != 5'd0) && ((ex_rt == id_rsel1) || (ex_rt == id_rsel2));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun, StDwait: begin
                if (wb_HALT) begin
                    state_d = StHalted;
                end else if (dmiss) begin
                    state_d = StDwait;
                end else begin
                    state_d = StRun;
                end
            end
            StHalted: state_d = StHalted;
            default:  state_d = StRun;
        endcase
    end

    // DWAIT shares RUN's output decode: a persisting miss re-asserts the freeze, dhit releases it.
    always_comb begin
        pc_W      = 1'b1;
        ifid_W    = 1'b1;
        idex_W    = 1'b1;
        exmem_W   = 1'b1;
        memwb_W   = 1'b1;
        ifid_RST  = 1'b0;
        idex_RST  = 1'b0;
        exmem_RST = 1'b0;
        memwb_RST = 1'b0;
        halted    = 1'b0;
        if (RST) begin
            pc_W      = 1'b0;
            ifid_W    = 1'b0;
            idex_W    = 1'b0;
            exmem_W   = 1'b0;
            memwb_W   = 1'b0;
            ifid_RST  = 1'b1;
            idex_RST  = 1'b1;
            exmem_RST = 1'b1;
            memwb_RST = 1'b1;
        end else if (state_q == StHalted) begin
            pc_W    = 1'b0;
            ifid_W  = 1'b0;
            idex_W  = 1'b0;
            exmem_W = 1'b0;
            memwb_W = 1'b0;
            halted  = 1'b1;
        end else if (dmiss) begin
            pc_W      = 1'b0;
            ifid_W    = 1'b0;
            idex_W    = 1'b0;
            exmem_W   = 1'b0;
            memwb_RST = 1'b1;
        end else if (mem_brtaken) begin
            ifid_RST  = 1'b1;
            idex_RST  = 1'b1;
            exmem_RST = 1'b1;
        end else if (luhaz) begin
            pc_W     = 1'b0;
            ifid_W   = 1'b0;
            idex_RST = 1'b1;
        end else if (!ihit) begin
            pc_W     = 1'b0;
            ifid_RST = 1'b1;
        end
    end

    assign stall_inc = !pc_W && (state_q != StHalted);
    assign flush_inc = (ifid_RST | idex_RST | exmem_RST | memwb_RST) && !RST;

    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (stall_inc && (stall_q != {CNT_W{1'b1}})) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (flush_inc && (flush_q != {CNT_W{1'b1}})) begin
                flush_q <= flush_q + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: a default-width instance plus a 4-bit-counter instance
// driven by the same stimulus for the saturation case.
module tb_pipeline_ctrl;

    logic        CLK = 1'b0;
    logic        RST, ihit, dhit, mem_DRE, mem_DWE, mem_brtaken, ex_DRE, wb_HALT;
    logic [4:0]  ex_rt, id_rsel1, id_rsel2;

    logic        pc_W, ifid_W, idex_W, exmem_W, memwb_W;
    logic        ifid_RST, idex_RST, exmem_RST, memwb_RST, halted;
    logic [31:0] stall_cnt, flush_cnt;

    logic        s_pc_W, s_ifid_W, s_idex_W, s_exmem_W, s_memwb_W;
    logic        s_ifid_RST, s_idex_RST, s_exmem_RST, s_memwb_RST, s_halted;
    logic [3:0]  s_stall_cnt, s_flush_cnt;

    int n_vec = 0;
    int n_bad = 0;

    // {pc, ifid, idex, exmem, memwb W} {ifid, idex, exmem, memwb RST} {halted}
    localparam logic [9:0] ONormal = 10'b11111_0000_0;
    localparam logic [9:0] OReset  = 10'b00000_1111_0;
    localparam logic [9:0] ODmiss  = 10'b00001_0001_0;
    localparam logic [9:0] OBranch = 10'b11111_1110_0;
    localparam logic [9:0] OLuhaz  = 10'b00111_0100_0;
    localparam logic [9:0] ONoIhit = 10'b01111_1000_0;
    localparam logic [9:0] OHalted = 10'b00000_0000_1;

    logic [9:0] outs;
    assign outs = {pc_W, ifid_W, idex_W, exmem_W, memwb_W,
                   ifid_RST, idex_RST, exmem_RST, memwb_RST, halted};

    always #5 CLK = ~CLK;

    pipeline_ctrl u_dut (
        .CLK        (CLK),
        .RST        (RST),
        .ihit       (ihit),
        .dhit       (dhit),
        .mem_DRE    (mem_DRE),
        .mem_DWE    (mem_DWE),
        .mem_brtaken(mem_brtaken),
        .ex_DRE     (ex_DRE),
        .ex_rt      (ex_rt),
        .id_rsel1   (id_rsel1),
        .id_rsel2   (id_rsel2),
        .wb_HALT    (wb_HALT),
        .pc_W       (pc_W),
        .ifid_W     (ifid_W),
        .idex_W     (idex_W),
        .exmem_W    (exmem_W),
        .memwb_W    (memwb_W),
        .ifid_RST   (ifid_RST),
        .idex_RST   (idex_RST),
        .exmem_RST  (exmem_RST),
        .memwb_RST  (memwb_RST),
        .halted     (halted),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
    );

    pipeline_ctrl #(.CNT_W(4)) u_dut_small (
        .CLK        (CLK),
        .RST        (RST),
        .ihit       (ihit),
        .dhit       (dhit),
        .mem_DRE    (mem_DRE),
        .mem_DWE    (mem_DWE),
        .mem_brtaken(mem_brtaken),
        .ex_DRE     (ex_DRE),
        .ex_rt      (ex_rt),
        .id_rsel1   (id_rsel1),
        .id_rsel2   (id_rsel2),
        .wb_HALT    (wb_HALT),
        .pc_W       (s_pc_W),
        .ifid_W     (s_ifid_W),
        .idex_W     (s_idex_W),
        .exmem_W    (s_exmem_W),
        .memwb_W    (s_memwb_W),
        .ifid_RST   (s_ifid_RST),
        .idex_RST   (s_idex_RST),
        .exmem_RST  (s_exmem_RST),
        .memwb_RST  (s_memwb_RST),
        .halted     (s_halted),
        .stall_cnt  (s_stall_cnt),
        .flush_cnt  (s_flush_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Idle = fetch hits, no memory op, no hazard, no halt.
    task automatic idle();
        RST = 1'b0; ihit = 1'b1; dhit = 1'b1; mem_DRE = 1'b0; mem_DWE = 1'b0;
        mem_brtaken = 1'b0; ex_DRE = 1'b0; ex_rt = 5'd0; id_rsel1 = 5'd0; id_rsel2 = 5'd0;
        wb_HALT = 1'b0;
    endtask

    // Inputs are set just after a negedge; outputs are checked 1 time unit later.
    task automatic step_check(input string tag, input logic [9:0] exp);
        #1;
        check(tag, 64'(outs), 64'(exp));
        @(negedge CLK);
    endtask

    task automatic check_cnt(input string tag, input int st, input int fl);
        check({tag, "_stall"}, 64'(stall_cnt), 64'(st));
        check({tag, "_flush"}, 64'(flush_cnt), 64'(fl));
    endtask

    initial begin
        @(negedge CLK);
        idle();
        RST = 1'b1;
        step_check("reset_outs0", OReset);
        RST = 1'b1;
        step_check("reset_outs1", OReset);
        idle();
        check_cnt("after_reset", 0, 0);
        check("small_after_reset", 64'({s_stall_cnt, s_flush_cnt}), 64'h0);
        step_check("normal", ONormal);
        check_cnt("normal", 0, 0);

        // Load-use hazard on rsel2.
        ex_DRE = 1'b1; ex_rt = 5'd5; id_rsel2 = 5'd5;
        step_check("luhaz", OLuhaz);
        idle();
        check_cnt("luhaz", 1, 1);
        // r0 never creates a hazard.
        ex_DRE = 1'b1; ex_rt = 5'd0; id_rsel1 = 5'd0;
        step_check("luhaz_r0", ONormal);
        idle();

        ihit = 1'b0;
        step_check("no_ihit", ONoIhit);
        idle();
        check_cnt("no_ihit", 2, 2);

        // Load miss for 3 cycles, then dhit.
        for (int i = 0; i < 3; i++) begin
            mem_DRE = 1'b1; dhit = 1'b0;
            step_check($sformatf("dmiss%0d", i), ODmiss);
        end
        dhit = 1'b1;
        step_check("dmiss_release", ONormal);
        idle();
        check_cnt("dmiss", 5, 5);

        // Branch wins over load-use.
        mem_brtaken = 1'b1; ex_DRE = 1'b1; ex_rt = 5'd7; id_rsel1 = 5'd7;
        step_check("branch_luhaz", OBranch);
        idle();
        check_cnt("branch_luhaz", 5, 6);

        // Store miss with taken branch: freeze twice, flush on dhit.
        for (int i = 0; i < 2; i++) begin
            mem_DWE = 1'b1; dhit = 1'b0; mem_brtaken = 1'b1;
            step_check($sformatf("miss_br%0d", i), ODmiss);
        end
        dhit = 1'b1;
        step_check("miss_br_flush", OBranch);
        idle();
        check_cnt("miss_br", 7, 9);

        // Halt: current cycle normal, then halted regardless of inputs.
        wb_HALT = 1'b1;
        step_check("halt_enter", ONormal);
        idle();
        step_check("halted0", OHalted);
        mem_DRE = 1'b1; dhit = 1'b0; ihit = 1'b0;
        step_check("halted1", OHalted);
        idle();
        check_cnt("halted", 7, 9);
        RST = 1'b1;
        step_check("halt_reset", OReset);
        idle();
        check_cnt("halt_reset", 0, 0);
        step_check("after_halt_reset", ONormal);

        // Halt arriving during a miss (DWAIT).
        mem_DRE = 1'b1; dhit = 1'b0;
        step_check("dwait_a", ODmiss);
        mem_DRE = 1'b1; dhit = 1'b0; wb_HALT = 1'b1;
        step_check("dwait_halt", ODmiss);
        idle();
        step_check("dwait_halted", OHalted);
        RST = 1'b1;
        step_check("reset2", OReset);
        idle();

        // 20 fetch-miss cycles: 4-bit counters saturate at 15.
        for (int i = 0; i < 20; i++) begin
            ihit = 1'b0;
            #1;
            if (outs !== ONoIhit) check($sformatf("sat_outs%0d", i), 64'(outs), 64'(ONoIhit));
            @(negedge CLK);
        end
        idle();
        check("sat_small_stall", 64'(s_stall_cnt), 64'd15);
        check("sat_small_flush", 64'(s_flush_cnt), 64'd15);
        check_cnt("sat_wide", 20, 20);
        step_check("sat_normal", ONormal);
        check("sat_hold", 64'(s_stall_cnt), 64'd15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1);
    end

endmodule
